// File: rtl/cache_fill_fsm.sv
// Block-fill miss handler: streams WORDS pipelined reads from memory into the cache.
// Define FILL_STATS_EN to add the miss_count / fill_cycles statistics ports.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_wr_addr,
  output logic              write_tag_array
`ifdef FILL_STATS_EN
  ,
  output logic [15:0]       miss_count,
  output logic [15:0]       fill_cycles
`endif
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C = CW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((WORDS * 2) - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;

  // Data goes straight to the data array; the FSM never inspects it.
  logic unused_data;
  assign unused_data = ^memory_data;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    rx_cnt_d         = rx_cnt_q;
    fsm_busy         = 1'b0;
    mem_read_req     = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_address   = base_q + ADDR_W'({issue_cnt_q, 1'b0});
    cache_wr_addr    = base_q + ADDR_W'({rx_cnt_q, 1'b0});
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          fsm_busy    = 1'b1;
          base_d      = miss_address & BLK_MASK;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy     = 1'b1;
        mem_read_req = issue_cnt_q < WORDS_C;
        if (mem_read_req) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        write_data_array = memory_data_valid
                         & (rx_cnt_q < issue_cnt_q);
        if (write_data_array) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_cnt_q == LAST_C) begin
            write_tag_array = 1'b1;
            issue_cnt_d     = '0;
            rx_cnt_d        = '0;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

`ifdef FILL_STATS_EN
  logic [15:0] miss_count_q, miss_count_d;
  logic [15:0] fill_cycles_q, fill_cycles_d;

  always_comb begin
    miss_count_d  = miss_count_q;
    fill_cycles_d = fill_cycles_q;
    if (state_q == IDLE && miss_detected && miss_count_q != 16'hFFFF) begin
      miss_count_d = miss_count_q + 16'd1;
    end
    if (state_q == FILL && fill_cycles_q != 16'hFFFF) begin
      fill_cycles_d = fill_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_count_q  <= '0;
      fill_cycles_q <= '0;
    end else begin
      miss_count_q  <= miss_count_d;
      fill_cycles_q <= fill_cycles_d;
    end
  end

  assign miss_count  = miss_count_q;
  assign fill_cycles = fill_cycles_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a pipelined-memory model.
// Build with FILL_STATS_EN defined to also check the statistics ports.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] cache_wr_addr;
  logic        write_tag_array;
`ifdef FILL_STATS_EN
  logic [15:0] miss_count;
  logic [15:0] fill_cycles;
`endif

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_req      (mem_read_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .cache_wr_addr     (cache_wr_addr),
    .write_tag_array   (write_tag_array)
`ifdef FILL_STATS_EN
    ,
    .miss_count        (miss_count),
    .fill_cycles       (fill_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    int          due;
  } pend_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    bit          tag;
  } wr_t;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  pend_t       pend[$];
  int          starts[$];
  int          tags[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 4;
  int gap_mode = 0;
  bit m_fill  = 0;
  bit start_now = 0;
  int wr_in_fill = 0;
  int m_misses = 0;
  int m_fcyc   = 0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the memory model's return path.
  task automatic step(input bit miss, input logic [15:0] addr,
                      input bit rst, input bit only_busy);
    bit idle_now;
    bit gap_ok;
    logic [15:0] base;
    @(posedge clk);
    cyc++;
    #1;
    idle_now  = !m_fill;
    start_now = 1'b0;
    if (only_busy && !m_fill) miss = 1'b0;
    rst_n         = !rst;
    miss_detected = miss;
    miss_address  = addr;
    if (rst) begin
      m_fill = 0;
      exp_req.delete();
      exp_wr.delete();
      m_misses = 0;
      m_fcyc = 0;
      wr_in_fill = 0;
    end else if (miss && !m_fill) begin
      base = addr & 16'hFFF0;
      for (int i = 0; i < 8; i++) begin
        exp_req.push_back(base + 16'(2 * i));
        exp_wr.push_back('{a: base + 16'(2 * i),
                           d: mem_fn(base + 16'(2 * i)),
                           tag: (i == 7)});
      end
      m_fill = 1;
      start_now = 1;
      m_misses++;
      wr_in_fill = 0;
      starts.push_back(cyc);
    end
    case (gap_mode)
      0: gap_ok = 1'b1;
      1: gap_ok = (cyc % 2) == 1;
      default: gap_ok = $urandom_range(0, 2) != 0;
    endcase
    memory_data_valid = 1'b0;
    memory_data = 16'($urandom);
    if (!rst && pend.size() > 0 && pend[0].due <= cyc && gap_ok) begin
      memory_data_valid = 1'b1;
      memory_data = mem_fn(pend[0].a);
      void'(pend.pop_front());
    end else if (!rst && idle_now && $urandom_range(0, 3) == 0) begin
      memory_data_valid = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] ea;
    wr_t ew;
    if (rst_n === 1'b1) begin
      if (m_fill && !start_now) m_fcyc++;
      chk("busy", 32'(fsm_busy), 32'(m_fill || miss_detected));
      if (mem_read_req) begin
        if (exp_req.size() == 0) begin
          chk("req_extra", 32'(memory_address), 32'hFFFFFFFF);
        end else begin
          ea = exp_req.pop_front();
          chk("req_addr", 32'(memory_address), 32'(ea));
        end
        pend.push_back('{a: memory_address, due: cyc + lat});
      end
      if (write_data_array) begin
        if (exp_wr.size() == 0) begin
          chk("wr_extra", 32'(cache_wr_addr), 32'hFFFFFFFF);
        end else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", 32'(cache_wr_addr), 32'(ew.a));
          chk("wr_data", 32'(memory_data), 32'(ew.d));
          chk("wr_tag", 32'(write_tag_array), 32'(ew.tag));
          wr_in_fill++;
          if (ew.tag) begin
            m_fill = 0;
            tags.push_back(cyc);
          end
        end
      end else if (write_tag_array) begin
        chk("tag_no_data", 32'(write_tag_array), 32'd0);
      end
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_fill(input logic [15:0] addr, input bit noise);
    int n;
    n = 0;
    while (pend.size() > 0 && n < 50) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      n++;
    end
    step(1'b1, addr, 1'b0, 1'b0);
    settle();
    n = 0;
    while (m_fill && n < 300) begin
      step(noise && $urandom_range(0, 2) == 0, 16'($urandom),
           1'b0, 1'b1);
      settle();
      n++;
    end
    if (m_fill) begin
      chk("fill_timeout", 32'(n), 32'd0);
      m_fill = 0;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data = '0;
    memory_data_valid = 1'b0;
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);
    settle();
    chk("rst_busy", 32'(fsm_busy), 32'd0);
    chk("rst_req", 32'(mem_read_req), 32'd0);
    chk("rst_wda", 32'(write_data_array), 32'd0);
    chk("rst_wta", 32'(write_tag_array), 32'd0);
`ifdef FILL_STATS_EN
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    chk("rst_fill_cycles", 32'(fill_cycles), 32'd0);
`endif

    // Latency 4, no gaps, stray misses mid-fill, then a back-to-back miss.
    lat = 4;
    gap_mode = 0;
    run_fill(16'h1236, 1'b1);
    run_fill(16'hFFF2, 1'b0);
    chk("fill1_len", 32'(tags[0] - starts[0]), 32'd12);
    chk("fill2_len", 32'(tags[1] - starts[1]), 32'd12);
    chk("back2back", 32'(starts[1] - tags[0]), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    settle();
`ifdef FILL_STATS_EN
    chk("miss_count_2", 32'(miss_count), 32'd2);
    chk("fill_cycles_24", 32'(fill_cycles), 32'd24);
`endif

    // Valid every other cycle.
    lat = 3;
    gap_mode = 1;
    run_fill(16'h1230, 1'b1);

    // Reset after the third returned word; late returns must be dropped.
    gap_mode = 0;
    lat = 4;
    step(1'b1, 16'h2468, 1'b0, 1'b0);
    settle();
    n = 0;
    while (wr_in_fill < 3 && n < 100) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      settle();
      n++;
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    settle();
    chk("abort_busy", 32'(fsm_busy), 32'd0);
    chk("abort_tag", 32'(write_tag_array), 32'd0);
    repeat (10) step(1'b0, 16'h0, 1'b0, 1'b0);

    // Randomised fills with random latency and gaps.
    gap_mode = 2;
    for (int k = 0; k < 25; k++) begin
      lat = $urandom_range(1, 6);
      run_fill(16'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) step(1'b0, 16'h0, 1'b0, 1'b0);
    end

    repeat (12) step(1'b0, 16'h0, 1'b0, 1'b0);
    settle();
    chk("req_drained", 32'(exp_req.size()), 32'd0);
    chk("wr_drained", 32'(exp_wr.size()), 32'd0);
`ifdef FILL_STATS_EN
    chk("miss_count_model", 32'(miss_count), 32'(m_misses));
    chk("fill_cycles_model", 32'(fill_cycles), 32'(m_fcyc));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
